pulpemu_gpio_ctrl: RTL and testbench
====================================

Name: pulpemu_gpio_ctrl

Overview:
Parametrised GPIO front-end between the PULP GPIO peripheral and FPGA pads, generalising the fixed 8-pin emulator GPIO glue to N_GPIO channels. Adds input synchronisation, a programmable per-channel glitch filter, edge detection with a sticky interrupt-pending register, and a registered output/output-enable path gated by the FMC/Zynq mode select. The pad side uses split in/out/oe signals; the vendor IOBUFs are instantiated at the top level.

Parameters:
N_GPIO, 8, number of GPIO channels (1..32)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
FILT_W, 4, width of glitch-filter counter and of filt_len_i

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
mode_fmc_zynqn_i  input  1  1 = PULP owns pads, 0 = pads tristated
gpio_out_i  input  N_GPIO  output values from PULP
gpio_dir_i  input  N_GPIO  1 = output, per channel
gpio_in_o  output  N_GPIO  filtered input values to PULP
filt_len_i  input  FILT_W  extra stable cycles required; 0 = no extra filtering
irq_en_rise_i  input  N_GPIO  rising-edge interrupt enable
irq_en_fall_i  input  N_GPIO  falling-edge interrupt enable
irq_clr_i  input  N_GPIO  write-1-to-clear pulse for pending bits
irq_pend_o  output  N_GPIO  sticky pending bits
irq_o  output  1  OR of irq_pend_o, registered
pad_i  input  N_GPIO  pad input (asynchronous)
pad_o  output  N_GPIO  pad output value
pad_oe_o  output  N_GPIO  pad output enable, 1 = drive

Behaviour:
- Reset (rst_i high at a clock edge): all synchroniser flops, filtered values, filter counters, edge-history flops, irq_pend_o, irq_o, pad_o and pad_oe_o go to 0. Asserting reset mid-operation drops all pending interrupts and any filter count in progress.
- Output path: pad_o <= gpio_out_i; pad_oe_o <= gpio_dir_i & {N_GPIO{mode_fmc_zynqn_i}}. Both are registered, with one cycle of latency. When mode is 0, every pad is tristated within one cycle, regardless of dir.
- Input sync: pad_i passes through a SYNC_STAGES-deep flop chain per channel, giving the synchronised value s.
- Glitch filter, per channel, on the filtered value f and counter cnt:
  - If s == f: cnt <= 0.
  - Else if cnt >= filt_len_i: f <= s and cnt <= 0.
  - Else: cnt <= cnt + 1.
  - cnt never wraps. The >= compare means a mid-count decrease of filt_len_i takes effect immediately.
  - Any glitch shorter than filt_len_i+1 cycles at s is rejected, because cnt resets whenever s returns to f.
- gpio_in_o = f, taken directly from the filter register. Latency from a pad change to gpio_in_o is SYNC_STAGES + 1 + filt_len_i cycles. Inputs are sampled regardless of direction, so an output-configured pin reads back its pad value.
- Edge detect: f_q is f delayed by one cycle. rise = f & ~f_q; fall = ~f & f_q. Edges are detected on every channel; enables gate only the pending-bit set.
- Pending bits: set = (rise & irq_en_rise_i) | (fall & irq_en_fall_i).
  - irq_pend <= (irq_pend & ~irq_clr_i) | set.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Clearing a bit that is not pending has no effect.
- irq_o <= |next_irq_pend, so irq_o asserts in the same cycle irq_pend_o does.
- Disabling an enable does not clear a bit that is already pending.
- mode_fmc_zynqn_i does not affect the input path.
- No combinational path from any input to any output.

Test Plan:
1. Reset: drive rst_i for 2 cycles with pad_i=8'hFF and gpio_dir_i=8'hFF -> pad_oe_o=0, pad_o=0, gpio_in_o=0, irq_o=0 during reset and on the first cycle after it.
2. Output/mode (N_GPIO=8): mode=1, dir=8'h0F, out=8'hA5 -> one cycle later pad_oe_o=8'h0F and pad_o=8'hA5. Drop mode to 0 -> pad_oe_o=8'h00 on the next cycle, pad_o unchanged.
3. Latency: filt_len_i=0, SYNC_STAGES=2, pad_i[3] goes 0->1 -> gpio_in_o[3]=1 exactly 3 cycles later. With filt_len_i=4 -> 7 cycles later.
4. Glitch rejection: filt_len_i=4, pad_i[0] pulses high for 4 cycles -> gpio_in_o[0] stays 0 and irq_pend_o stays 0. A 5-cycle pulse -> gpio_in_o[0] goes high for 5 cycles.
5. Interrupts: irq_en_rise=8'h01, irq_en_fall=8'h02; rise on ch0, fall on ch1, rise on ch1 -> irq_pend_o=8'h03 and irq_o=1. Pulse irq_clr_i=8'h01 -> 8'h02. Pulse irq_clr_i=8'h02 -> 8'h00 and irq_o=0.
6. Set/clear collision: in the cycle an enabled ch2 rise is detected, pulse irq_clr_i=8'h04 -> irq_pend_o[2]=1. Then assert rst_i for 1 cycle -> irq_pend_o=0.

Source files
------------

// File: rtl/pulpemu_gpio_ctrl.sv
// GPIO front-end between the PULP GPIO peripheral and FPGA pads: input sync,
// per-channel glitch filter, edge-triggered sticky interrupts and registered pad drive.
module pulpemu_gpio_ctrl #(
  parameter int N_GPIO      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mode_fmc_zynqn_i,
  input  logic [N_GPIO-1:0] gpio_out_i,
  input  logic [N_GPIO-1:0] gpio_dir_i,
  output logic [N_GPIO-1:0] gpio_in_o,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [N_GPIO-1:0] irq_en_rise_i,
  input  logic [N_GPIO-1:0] irq_en_fall_i,
  input  logic [N_GPIO-1:0] irq_clr_i,
  output logic [N_GPIO-1:0] irq_pend_o,
  output logic              irq_o,
  input  logic [N_GPIO-1:0] pad_i,
  output logic [N_GPIO-1:0] pad_o,
  output logic [N_GPIO-1:0] pad_oe_o
);

  logic [N_GPIO-1:0] sync_p0 [SYNC_STAGES];
  logic [N_GPIO-1:0] filt_p1;
  logic [FILT_W-1:0] cnt_p1  [N_GPIO];
  logic [N_GPIO-1:0] filt_p2;
  logic [N_GPIO-1:0] pend_q;
  logic [N_GPIO-1:0] pend_nxt;
  logic [N_GPIO-1:0] set_vec;
  logic              irq_q;
  logic [N_GPIO-1:0] pad_q;
  logic [N_GPIO-1:0] pad_oe_q;
  logic [N_GPIO-1:0] sync_s;

  // Pad output stage: mode low tristates every pad on the next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_q    <= '0;
      pad_oe_q <= '0;
    end else begin
      pad_q    <= gpio_out_i;
      pad_oe_q <= gpio_dir_i & {N_GPIO{mode_fmc_zynqn_i}};
    end
  end

  // Stage p0: asynchronous pad inputs through the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  assign sync_s = sync_p0[SYNC_STAGES-1];

  // Stage p1: glitch filter; the count restarts whenever s returns to f,
  // and cnt only increments while below filt_len_i so it cannot wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_p1 <= '0;
      for (int ch = 0; ch < N_GPIO; ch++) cnt_p1[ch] <= '0;
    end else begin
      for (int ch = 0; ch < N_GPIO; ch++) begin
        if (sync_s[ch] == filt_p1[ch]) begin
          cnt_p1[ch] <= '0;
        end else if (cnt_p1[ch] >= filt_len_i) begin
          filt_p1[ch] <= sync_s[ch];
          cnt_p1[ch]  <= '0;
        end else begin
          cnt_p1[ch] <= cnt_p1[ch] + FILT_W'(1);
        end
      end
    end
  end

  assign set_vec  = (filt_p1 & ~filt_p2 & irq_en_rise_i) |
                    (~filt_p1 & filt_p2 & irq_en_fall_i);
  assign pend_nxt = (pend_q & ~irq_clr_i) | set_vec;

  // Stage p2: edge history and sticky pending bits (set beats clear).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_p2 <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      filt_p2 <= filt_p1;
      pend_q  <= pend_nxt;
      irq_q   <= |pend_nxt;
    end
  end

  assign gpio_in_o  = filt_p1;
  assign irq_pend_o = pend_q;
  assign irq_o      = irq_q;
  assign pad_o      = pad_q;
  assign pad_oe_o   = pad_oe_q;

endmodule

// File: tb/tb_pulpemu_gpio_ctrl.sv
// Scoreboard bench for pulpemu_gpio_ctrl: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_pulpemu_gpio_ctrl;

  localparam int N = 8;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          mode;
  logic [N-1:0]  gout, gdir, gin, en_r, en_f, clr, pend, pad_in, pad_out, pad_oe;
  logic [FW-1:0] flen;
  logic          irq;

  pulpemu_gpio_ctrl #(.N_GPIO(N), .SYNC_STAGES(2), .FILT_W(FW)) dut (
    .clk_i(clk), .rst_i(rst_i), .mode_fmc_zynqn_i(mode),
    .gpio_out_i(gout), .gpio_dir_i(gdir), .gpio_in_o(gin),
    .filt_len_i(flen), .irq_en_rise_i(en_r), .irq_en_fall_i(en_f),
    .irq_clr_i(clr), .irq_pend_o(pend), .irq_o(irq),
    .pad_i(pad_in), .pad_o(pad_out), .pad_oe_o(pad_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] mask;
    logic [31:0] ev;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sorted insert keeps the queue ordered by the cycle it is due in.
  task automatic expect_at(input string nm, input int sel, input logic [31:0] mask,
                           input logic [31:0] ev, input int dly);
    exp_t e;
    int   idx;
    e.cyc = cyc + dly; e.sel = sel; e.mask = mask; e.ev = ev; e.nm = nm;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin idx = i; break; end
    end
    sb.insert(idx, e);
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      0: probe = 32'(pad_out);
      1: probe = 32'(pad_oe);
      2: probe = 32'(gin);
      3: probe = 32'(pend);
      default: probe = 32'(irq);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = probe(e.sel) & e.mask;
      checks++;
      if (act !== (e.ev & e.mask)) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.nm, cyc, act, e.ev & e.mask);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; mode = 1'b1; gout = '1; gdir = '1; pad_in = '1;
    flen = '0; en_r = '0; en_f = '0; clr = '0;

    // Reset holds everything low while pads and dir are all ones.
    for (int d = 1; d <= 2; d++) begin
      expect_at("rst_oe",   1, 32'hFF, 32'h00, d);
      expect_at("rst_out",  0, 32'hFF, 32'h00, d);
      expect_at("rst_in",   2, 32'hFF, 32'h00, d);
      expect_at("rst_irq",  4, 32'h01, 32'h00, d);
      expect_at("rst_pend", 3, 32'hFF, 32'h00, d);
    end
    step(2);
    rst_i = 1'b0; pad_in = '0;
    expect_at("post_rst_oe", 1, 32'hFF, 32'hFF, 1);
    expect_at("post_rst_in", 2, 32'hFF, 32'h00, 1);
    expect_at("post_rst_irq", 4, 32'h01, 32'h00, 1);

    // Output path and mode gating.
    step(1);
    gdir = 8'h0F; gout = 8'hA5;
    expect_at("oe_mode1", 1, 32'hFF, 32'h0F, 1);
    expect_at("out_mode1", 0, 32'hFF, 32'hA5, 1);
    step(1);
    mode = 1'b0;
    expect_at("oe_mode0", 1, 32'hFF, 32'h00, 1);
    expect_at("out_mode0", 0, 32'hFF, 32'hA5, 1);
    step(1);

    // Latency with filt_len 0: 3 cycles; input path ignores mode.
    step(4);
    pad_in[3] = 1'b1;
    expect_at("lat0_early", 2, 32'h08, 32'h00, 2);
    expect_at("lat0_hit",   2, 32'h08, 32'h08, 3);
    step(4);
    pad_in[3] = 1'b0;
    step(5);
    mode = 1'b1;
    flen = 4'd4;
    step(1);
    pad_in[3] = 1'b1;
    expect_at("lat4_early", 2, 32'h08, 32'h00, 6);
    expect_at("lat4_hit",   2, 32'h08, 32'h08, 7);
    step(8);

    // 4-cycle glitch on ch0 is rejected, no interrupt.
    en_r = 8'h01;
    step(1);
    pad_in[0] = 1'b1;
    for (int d = 2; d <= 12; d++) expect_at("glitch4_in", 2, 32'h01, 32'h00, d);
    expect_at("glitch4_pend", 3, 32'hFF, 32'h00, 12);
    step(4);
    pad_in[0] = 1'b0;
    step(10);

    // 5-cycle pulse passes as a 5-cycle high on gpio_in_o[0].
    pad_in[0] = 1'b1;
    expect_at("pulse5_pre", 2, 32'h01, 32'h00, 6);
    for (int d = 7; d <= 11; d++) expect_at("pulse5_hi", 2, 32'h01, 32'h01, d);
    expect_at("pulse5_post", 2, 32'h01, 32'h00, 12);
    expect_at("pulse5_pend", 3, 32'hFF, 32'h01, 8);
    expect_at("pulse5_irq",  4, 32'h01, 32'h01, 8);
    step(5);
    pad_in[0] = 1'b0;
    step(10);
    clr = 8'h01;
    expect_at("pulse5_clr", 3, 32'hFF, 32'h00, 1);
    expect_at("pulse5_clr_irq", 4, 32'h01, 32'h00, 1);
    step(1);
    clr = '0;
    flen = 4'd0;
    step(5);

    // Interrupts: rise ch0 enabled, fall ch1 enabled, rise ch1 not.
    en_r = 8'h01; en_f = 8'h02;
    pad_in = 8'h03;
    expect_at("irq_rise0", 3, 32'hFF, 32'h01, 4);
    step(4);
    pad_in = 8'h01;
    expect_at("irq_fall1_pre", 3, 32'hFF, 32'h01, 3);
    expect_at("irq_fall1", 3, 32'hFF, 32'h03, 4);
    expect_at("irq_fall1_o", 4, 32'h01, 32'h01, 4);
    step(5);
    en_r = 8'h00;
    clr = 8'h01;
    expect_at("clr0", 3, 32'hFF, 32'h02, 1);
    expect_at("clr0_irq", 4, 32'h01, 32'h01, 1);
    step(1);
    clr = 8'h00;
    step(1);
    clr = 8'h02;
    expect_at("clr1", 3, 32'hFF, 32'h00, 1);
    expect_at("clr1_irq", 4, 32'h01, 32'h00, 1);
    step(1);
    clr = 8'h00;
    step(2);

    // Set/clear collision on ch2, then reset drops it.
    en_r = 8'h04; en_f = 8'h00;
    pad_in[2] = 1'b1;
    step(3);
    clr = 8'h04;
    expect_at("collide_pend", 3, 32'hFF, 32'h04, 1);
    expect_at("collide_irq",  4, 32'h01, 32'h01, 1);
    step(1);
    clr = 8'h00;
    step(1);
    rst_i = 1'b1;
    expect_at("rst2_pend", 3, 32'hFF, 32'h00, 1);
    expect_at("rst2_irq",  4, 32'h01, 32'h00, 1);
    expect_at("rst2_in",   2, 32'hFF, 32'h00, 1);
    expect_at("rst2_oe",   1, 32'hFF, 32'h00, 1);
    step(1);
    rst_i = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
